// File: rtl/node_irq_arbiter_pkg.sv
// Shared definitions for the node interrupt arbiter.
//   N_BUS_DEF       : default number of CAN bus request lines
//   ID_W_DEF        : default width of a bus index (clog2 of N_BUS_DEF)
//   TIMEOUT_CYC_DEF : default number of cycles a grant may wait for ack
//   arb_state_e     : arbiter FSM state type
package mopshub_arb_pkg;

    localparam int unsigned N_BUS_DEF       = 32;
    localparam int unsigned ID_W_DEF        = 5;
    localparam int unsigned TIMEOUT_CYC_DEF = 1024;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/node_irq_arbiter_if.sv
// Request/grant bundle between the decoder/consumer side and the arbiter.
//   req_vec      : per-bus request bits from the upstream decoder stage
//   en_mask      : per-bus enable, 0 excludes the bus from arbitration
//   grant_ack    : consumer finished servicing the granted bus
//   grant_valid  : grant_id / grant_onehot are valid
//   grant_id     : index of the granted bus
//   grant_onehot : one-hot grant, all-zero when grant_valid = 0
//   timeout      : one-cycle pulse when a grant is abandoned without ack
//   pending      : sticky pending-request register
// Modports: master = decoder/consumer side, slave = arbiter.
interface node_irq_arbiter_if
    import mopshub_arb_pkg::*;
#(
    parameter int unsigned N_BUS = N_BUS_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
) ();

    logic [N_BUS-1:0] req_vec;
    logic [N_BUS-1:0] en_mask;
    logic             grant_ack;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic [N_BUS-1:0] grant_onehot;
    logic             timeout;
    logic [N_BUS-1:0] pending;

    modport master (
        output req_vec, en_mask, grant_ack,
        input  grant_valid, grant_id, grant_onehot, timeout, pending
    );

    modport slave (
        input  req_vec, en_mask, grant_ack,
        output grant_valid, grant_id, grant_onehot, timeout, pending
    );

endinterface

// File: rtl/node_irq_arbiter_rr_priority_sel.sv
// Rotating-priority selector: returns the first set bit of req, searching
// ptr, ptr+1, ..., N_BUS-1, 0, ..., ptr-1.
//   req   : candidate request vector
//   ptr   : search start index (must be < N_BUS)
//   idx   : selected index (0 when nothing found)
//   found : at least one request bit set
module rr_priority_sel
    import mopshub_arb_pkg::*;
#(
    parameter int unsigned N_BUS = N_BUS_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
) (
    input  logic [N_BUS-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  idx,
    output logic             found
);

    always_comb begin
        int unsigned pos;
        pos   = 0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_BUS; k++) begin
            // Wrap the search position without a modulo operator.
            pos = 32'(ptr) + k;
            if (pos >= N_BUS) begin
                pos = pos - N_BUS;
            end
            if (!found && req[ID_W'(pos)]) begin
                found = 1'b1;
                idx   = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/node_irq_arbiter.sv
// Round-robin interrupt arbiter for the CAN bus request lines.
// Rising edges on req_vec latch sticky pending bits; an IDLE/GRANT FSM hands
// one enabled pending bus at a time to the consumer and releases it on
// grant_ack or after TIMEOUT_CYC cycles without ack.
//   clk : system clock, rising edge
//   rst : synchronous reset, active low
//   bus : request/grant bundle (slave side)
module node_irq_arbiter
    import mopshub_arb_pkg::*;
#(
    parameter int unsigned N_BUS       = N_BUS_DEF,
    parameter int unsigned ID_W        = ID_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    node_irq_arbiter_if.slave  bus
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_BUS - 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [N_BUS-1:0] req_prev;
    logic [N_BUS-1:0] pending;
    logic [N_BUS-1:0] rise;
    logic [N_BUS-1:0] avail;
    logic [N_BUS-1:0] clr_mask;
    logic [N_BUS-1:0] onehot_q;
    logic [ID_W-1:0]  grant_id_q;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  sel_idx;
    logic [CNT_W-1:0] wait_cnt;
    logic             sel_found;
    logic             ack_hit;
    logic             to_hit;
    logic             release_grant;

    assign rise          = bus.req_vec & ~req_prev;
    assign avail         = pending & bus.en_mask;
    assign ack_hit       = (state == ST_GRANT) && bus.grant_ack;
    // An ack on the last allowed cycle is a normal completion, not a timeout.
    assign to_hit        = (state == ST_GRANT) && !bus.grant_ack && (wait_cnt == CNT_LAST);
    assign release_grant = ack_hit || to_hit;
    assign clr_mask      = release_grant ? onehot_q : '0;

    rr_priority_sel #(
        .N_BUS (N_BUS),
        .ID_W  (ID_W)
    ) u_sel (
        .req   (avail),
        .ptr   (ptr),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (sel_found)     state_nxt = ST_GRANT;
            ST_GRANT: if (release_grant) state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // Outputs; timeout is masked while rst is asserted so a grant abandoned
    // by reset never pulses it.
    always_comb begin
        bus.grant_valid  = (state == ST_GRANT);
        bus.grant_onehot = (state == ST_GRANT) ? onehot_q : '0;
        bus.grant_id     = grant_id_q;
        bus.timeout      = to_hit && rst;
        bus.pending      = pending;
    end

    // Pending register, grant capture, wait counter and rotation pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_prev   <= '0;
            pending    <= '0;
            ptr        <= '0;
            grant_id_q <= '0;
            onehot_q   <= '0;
            wait_cnt   <= '0;
        end else begin
            req_prev <= bus.req_vec;
            // A new edge on the bus being released keeps its pending bit.
            pending  <= (pending & ~clr_mask) | rise;
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        grant_id_q <= sel_idx;
                        onehot_q   <= N_BUS'(1) << sel_idx;
                        wait_cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (release_grant) begin
                        ptr <= (grant_id_q == ID_LAST) ? '0 : grant_id_q + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
